// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer: holds the MMCM in reset, waits for a stable lock, then releases the
// downstream reset domains in ascending order. Optional soft reset path: define SOFT_RESET_EN.
module clk_rst_sequencer #(
  parameter int unsigned N_DOMAINS          = 2,
  parameter int unsigned MMCM_RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT       = 4096,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned STAGE_DELAY        = 8,
  parameter int unsigned CNT_W              = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mmcm_locked,
`ifdef SOFT_RESET_EN
  input  logic                 soft_rst_req,
`endif
  output logic                 mmcm_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic [CNT_W-1:0]     relock_cnt,
  output logic                 timeout_err
);

  localparam int unsigned MaxA = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES :
                                                                     STAGE_DELAY;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned TW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IW     = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [TW-1:0] RstLast    = TW'(MMCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] ToLast     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] StableLast = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] StageLast  = TW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] LastIdx    = IW'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    StMrst,
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d, idx_nxt;
  logic [1:0]             sync_q;
  logic                   mmcm_rst_q, mmcm_rst_d;
  logic [N_DOMAINS-1:0]   dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       relock_q, relock_d;
  logic                   terr_q, terr_d;
  logic                   lk;
  logic                   go_mrst, bump;

  assign lk      = sync_q[1];
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    mmcm_rst_d = mmcm_rst_q;
    dom_d      = dom_q;
    ready_d    = ready_q;
    relock_d   = relock_q;
    terr_d     = terr_q;
    go_mrst    = 1'b0;
    bump       = 1'b0;

    unique case (state_q)
      StMrst: begin
        if (cnt_q == RstLast) begin
          state_d    = StWaitLock;
          cnt_d      = '0;
          mmcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (lk) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == ToLast) begin
          go_mrst = 1'b1;
          bump    = 1'b1;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStable: begin
        // A dropout here is treated as a glitch: restart the wait, no relock count.
        if (!lk) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d  = StRelease;
          cnt_d    = '0;
          idx_d    = '0;
          dom_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!lk) begin
          go_mrst = 1'b1;
          bump    = 1'b1;
        end else if (cnt_q == StageLast) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            idx_d          = idx_nxt;
            dom_d[idx_nxt] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lk) begin
          go_mrst = 1'b1;
          bump    = 1'b1;
        end
      end
      default: state_d = StMrst;
    endcase

`ifdef SOFT_RESET_EN
    // Soft request overrides any lock event on the same cycle and is not counted.
    if (soft_rst_req && (state_q != StMrst)) begin
      go_mrst = 1'b1;
      bump    = 1'b0;
      terr_d  = terr_q;
    end
`endif

    if (go_mrst) begin
      state_d    = StMrst;
      cnt_d      = '0;
      mmcm_rst_d = 1'b1;
      dom_d      = '1;
      ready_d    = 1'b0;
    end
    if (bump && (relock_q != '1)) begin
      relock_d = relock_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= StMrst;
      cnt_q      <= '0;
      idx_q      <= '0;
      mmcm_rst_q <= 1'b1;
      dom_q      <= '1;
      ready_q    <= 1'b0;
      relock_q   <= '0;
      terr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], mmcm_locked};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mmcm_rst_q <= mmcm_rst_d;
      dom_q      <= dom_d;
      ready_q    <= ready_d;
      relock_q   <= relock_d;
      terr_q     <= terr_d;
    end
  end

  assign mmcm_rst    = mmcm_rst_q;
  assign domain_rst  = dom_q;
  assign ready       = ready_q;
  assign relock_cnt  = relock_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: vector table, directed corner sequences and random lock
// activity, all checked every cycle against a phase/age reference model.
module tb_clk_rst_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned M  = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned LS = 5;
  localparam int unsigned S  = 3;
  localparam int unsigned CW = 2;

  localparam int PhMrst   = 0;
  localparam int PhWait   = 1;
  localparam int PhStable = 2;
  localparam int PhRel    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mmcm_locked = 1'b0;
  logic          soft_drv = 1'b0;
  logic          mmcm_rst;
  logic [N-1:0]  domain_rst;
  logic          ready;
  logic [CW-1:0] relock_cnt;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .N_DOMAINS         (N),
    .MMCM_RST_CYCLES   (M),
    .LOCK_TIMEOUT      (TO),
    .LOCK_STABLE_CYCLES(LS),
    .STAGE_DELAY       (S),
    .CNT_W             (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mmcm_locked (mmcm_locked),
`ifdef SOFT_RESET_EN
    .soft_rst_req(soft_drv),
`endif
    .mmcm_rst    (mmcm_rst),
    .domain_rst  (domain_rst),
    .ready       (ready),
    .relock_cnt  (relock_cnt),
    .timeout_err (timeout_err)
  );

  // Reference model: a phase plus the number of cycles spent in it; release/run are one phase
  // whose outputs follow arithmetically from its age.
  int   ph, age, m_relock;
  logic m_terr, hist0, hist1;

  task automatic model_reset();
    ph = PhMrst; age = 0; m_relock = 0; m_terr = 1'b0; hist0 = 1'b0; hist1 = 1'b0;
  endtask

  task automatic bump();
    if (m_relock < (1 << CW) - 1) m_relock++;
  endtask

  task automatic model_step(input logic locked_in, input logic soft_in);
    logic lk;
    lk = hist1; hist1 = hist0; hist0 = locked_in;
    if (soft_in && ph != PhMrst) begin
      ph = PhMrst; age = 0;
    end else begin
      case (ph)
        PhMrst: begin
          age++;
          if (age == M) begin ph = PhWait; age = 0; end
        end
        PhWait: begin
          if (lk) begin ph = PhStable; age = 0; end
          else begin
            age++;
            if (age == TO) begin ph = PhMrst; age = 0; m_terr = 1'b1; bump(); end
          end
        end
        PhStable: begin
          if (!lk) begin ph = PhWait; age = 0; end
          else begin
            age++;
            if (age == LS) begin ph = PhRel; age = 0; end
          end
        end
        default: begin
          if (!lk) begin ph = PhMrst; age = 0; bump(); end
          else if (age < N * S) age++;
        end
      endcase
    end
  endtask

  function automatic logic [N-1:0] exp_dom();
    int rel;
    logic [N-1:0] m;
    rel = 0;
    if (ph == PhRel) begin
      rel = age / S + 1;
      if (rel > N) rel = N;
    end
    m = '1;
    for (int b = 0; b < N; b++) if (b < rel) m[b] = 1'b0;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Packed as {mmcm_rst, domain_rst, ready, relock_cnt, timeout_err}.
  task automatic model_check(input string name);
    logic [31:0] got, exp;
    logic        e_rdy;
    logic [CW-1:0] e_cnt;
    e_rdy = (ph == PhRel) && (age >= N * S);
    e_cnt = m_relock[CW-1:0];
    got = 32'({mmcm_rst, domain_rst, ready, relock_cnt, timeout_err});
    exp = 32'({ph == PhMrst, exp_dom(), e_rdy, e_cnt, m_terr});
    check(name, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(mmcm_locked, soft_drv);
      #1;
      model_check("model");
    end
  endtask

  // Asserted between edges so the reset values must appear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("async_reset", 32'({mmcm_rst, domain_rst, ready, relock_cnt, timeout_err}),
          32'({1'b1, {N{1'b1}}, 1'b0, {CW{1'b0}}, 1'b0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    int unsigned   cycles;
    logic          locked;
    logic          mrst;
    logic [N-1:0]  dom;
    logic          rdy;
    logic [CW-1:0] cnt;
    logic          terr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int hold;
    // Power-up with lock 10 cycles after reset, then a loss in RUN and recovery.
    vecs[0]  = '{1,  1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{2,  1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1,  1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{6,  1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{7,  1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1,  1'b1, 1'b0, 3'b110, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{2,  1'b1, 1'b0, 3'b110, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1,  1'b1, 1'b0, 3'b100, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{3,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{2,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{1,  1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0};
    vecs[11] = '{1,  1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0};
    vecs[12] = '{1,  1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0};
    vecs[13] = '{1,  1'b0, 1'b1, 3'b111, 1'b0, 2'd1, 1'b0};
    vecs[14] = '{40, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 1'b0};

    #3;
    do_reset();
    for (int v = 0; v < 15; v++) begin
      mmcm_locked = vecs[v].locked;
      tick(int'(vecs[v].cycles));
      check($sformatf("vec%0d", v),
            32'({mmcm_rst, domain_rst, ready, relock_cnt, timeout_err}),
            32'({vecs[v].mrst, vecs[v].dom, vecs[v].rdy, vecs[v].cnt, vecs[v].terr}));
    end

    // Lock never arrives: timeout every 24 cycles, counter saturates at 3.
    do_reset();
    mmcm_locked = 1'b0;
    tick(23);
    check("pre_timeout", 32'({mmcm_rst, timeout_err, relock_cnt}), 32'({1'b0, 1'b0, 2'd0}));
    tick(1);
    check("timeout1", 32'({mmcm_rst, timeout_err, relock_cnt}), 32'({1'b1, 1'b1, 2'd1}));
    tick(3);
    check("mrst_again", 32'(mmcm_rst), 32'(1));
    tick(1);
    check("mrst_end", 32'(mmcm_rst), 32'(0));
    tick(20);
    check("timeout2", 32'(relock_cnt), 32'(2));
    tick(24);
    check("timeout3", 32'(relock_cnt), 32'(3));
    tick(48);
    check("saturate", 32'(relock_cnt), 32'(3));

    // One-cycle dropout during STABLE delays the first release by three cycles.
    do_reset();
    mmcm_locked = 1'b1;
    tick(4);
    mmcm_locked = 1'b0;
    tick(1);
    mmcm_locked = 1'b1;
    tick(7);
    check("glitch_hold", 32'(domain_rst), 32'(3'b111));
    tick(1);
    check("glitch_rel", 32'({domain_rst, relock_cnt}), 32'({3'b110, 2'd0}));
    tick(20);
    check("glitch_run", 32'({ready, relock_cnt}), 32'({1'b1, 2'd0}));

`ifdef SOFT_RESET_EN
    soft_drv = 1'b1;
    tick(1);
    soft_drv = 1'b0;
    check("soft_rst", 32'({mmcm_rst, domain_rst, ready, relock_cnt}),
          32'({1'b1, 3'b111, 1'b0, 2'd0}));
    tick(30);
    check("soft_rerun", 32'({ready, relock_cnt}), 32'({1'b1, 2'd0}));
`endif

    // Random lock activity with occasional resets.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        mmcm_locked = ~mmcm_locked;
        hold = mmcm_locked ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 25));
      end
      hold--;
`ifdef SOFT_RESET_EN
      soft_drv = ($urandom_range(0, 299) == 0);
`endif
      if ($urandom_range(0, 999) == 0) do_reset();
      tick(1);
    end
    soft_drv = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
